// File: rtl/in_keypad.sv
// 4x4 matrix keypad scanner with debounce, packing two key nibbles into a bus-readable byte.
// Optional echo of the byte being composed is enabled by defining KEYPAD_ECHO_EN.
module in_keypad #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       cls,
    input  logic [3:0] col_n,
    input  logic       ipr_out,
    output logic [3:0] row_n,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       valid,
    output logic       overrun,
    output logic [7:0] echo
);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StWaitRel
    } state_e;

    localparam logic [15:0] PrescMax = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DebLimit = 4'(DEBOUNCE);

    state_e      state_q, state_d;
    logic [15:0] presc_q;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  key_q, key_d;
    logic        nibble_sel_q;
    logic [3:0]  entry_hi_q;
    logic [7:0]  in_reg_q;
    logic        valid_q;
    logic        overrun_q;

    logic        tick;
    logic        accept;
    logic        complete;
    logic [1:0]  low_col;

    assign tick     = (presc_q == PrescMax);
    assign complete = accept && nibble_sel_q;

    // Lowest-numbered active column wins when several are pressed.
    always_comb begin
        low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_n[i]) low_col = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        key_d   = key_q;
        accept  = 1'b0;
        case (state_q)
            StScan: begin
                if (tick) begin
                    if (col_n != 4'hF) begin
                        key_d   = {idx_q, low_col};
                        count_d = 4'd0;
                        state_d = StDebounce;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (!col_n[key_q[1:0]]) begin
                        if (count_q + 4'd1 == DebLimit) begin
                            accept  = 1'b1;
                            count_d = 4'd0;
                            state_d = StWaitRel;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StWaitRel: begin
                if (tick) begin
                    if (col_n == 4'hF) begin
                        if (count_q + 4'd1 == DebLimit) begin
                            count_d = 4'd0;
                            idx_d   = idx_q + 2'd1;
                            state_d = StScan;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        count_d = 4'd0;
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge cls) begin
        if (!cls) begin
            state_q <= StScan;
            presc_q <= 16'd0;
            idx_q   <= 2'd0;
            count_q <= 4'd0;
            key_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
            idx_q   <= idx_d;
            count_q <= count_d;
            key_q   <= key_d;
        end
    end

    always_ff @(posedge clk or negedge cls) begin
        if (!cls) begin
            nibble_sel_q <= 1'b0;
            entry_hi_q   <= 4'd0;
            in_reg_q     <= 8'd0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (accept) begin
                if (!nibble_sel_q) begin
                    entry_hi_q   <= key_q;
                    nibble_sel_q <= 1'b1;
                end else begin
                    in_reg_q     <= {entry_hi_q, key_q};
                    entry_hi_q   <= 4'd0;
                    nibble_sel_q <= 1'b0;
                end
            end
            // A completing byte beats a simultaneous read: valid stays set, overrun holds.
            if (complete) begin
                valid_q <= 1'b1;
                if (valid_q && !ipr_out) overrun_q <= 1'b1;
            end else if (ipr_out) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign row_n   = ~(4'b0001 << idx_q);
    assign bus_out = in_reg_q;
    assign bus_oe  = ipr_out;
    assign valid   = valid_q;
    assign overrun = overrun_q;

`ifdef KEYPAD_ECHO_EN
    assign echo = (!nibble_sel_q && valid_q) ? in_reg_q : {entry_hi_q, 4'h0};
`else
    assign echo = 8'h00;
`endif

endmodule

// File: tb/tb_in_keypad.sv
// Self-checking bench for in_keypad: vector table, corner-case sequences and random key entry
// against a byte-assembly reference model.
module tb_in_keypad;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned Debounce = 2;
`ifdef KEYPAD_ECHO_EN
    localparam bit EchoOn = 1'b1;
`else
    localparam bit EchoOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       cls;
    logic [3:0] col_n;
    logic       ipr_out;
    logic [3:0] row_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       valid;
    logic       overrun;
    logic [7:0] echo;

    in_keypad #(
        .SCAN_DIV (ScanDiv),
        .DEBOUNCE (Debounce)
    ) dut (
        .clk     (clk),
        .cls     (cls),
        .col_n   (col_n),
        .ipr_out (ipr_out),
        .row_n   (row_n),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .valid   (valid),
        .overrun (overrun),
        .echo    (echo)
    );

    always #5 clk = ~clk;

    // Keypad matrix: pressed switches pull their columns low only while their row is driven.
    logic       pressed;
    logic [1:0] prow;
    logic [3:0] pmask;
    always_comb begin
        col_n = 4'hF;
        if (pressed && !row_n[prow]) col_n = ~pmask;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: nibbles pair up into bytes; unread bytes flag overrun.
    bit         m_half;
    logic [3:0] m_hi;
    logic [7:0] m_reg;
    bit         m_valid;
    bit         m_ovr;

    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [3:0] m);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) c = 2'(i);
        return {r, c};
    endfunction

    function automatic logic [7:0] m_echo();
        if (!EchoOn) return 8'h00;
        if (m_half) return {m_hi, 4'h0};
        if (m_valid) return m_reg;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_half = 0; m_hi = 4'h0; m_reg = 8'h00; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_key(input logic [3:0] k);
        if (!m_half) begin
            m_hi   = k;
            m_half = 1;
        end else begin
            m_half = 0;
            if (m_valid) m_ovr = 1;
            m_reg   = {m_hi, k};
            m_valid = 1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".bus_out"}, bus_out, m_reg);
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, m_valid});
        check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        check({tag, ".echo"}, echo, m_echo());
    endtask

    task automatic enter_key(input logic [1:0] r, input logic [3:0] m);
        @(negedge clk);
        prow = r; pmask = m; pressed = 1'b1;
        repeat (40) @(negedge clk);
        pressed = 1'b0;
        repeat (40) @(negedge clk);
        model_key(key_of(r, m));
    endtask

    task automatic do_read();
        @(negedge clk);
        ipr_out = 1'b1;
        #1;
        check("read.bus_oe", {7'd0, bus_oe}, 8'd1);
        check("read.bus_out", bus_out, m_reg);
        @(negedge clk);
        ipr_out = 1'b0;
        m_valid = 0; m_ovr = 0;
        check("read.valid_cleared", {7'd0, valid}, 8'd0);
        check("read.overrun_cleared", {7'd0, overrun}, 8'd0);
    endtask

    task automatic wait_row(input logic [1:0] r, output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (row_n == ~(4'b0001 << r)) ok = 1;
        end
        if (!ok) check("wait_row_timeout", 8'd0, 8'd1);
    endtask

    // Presses the key the moment its row comes up; returns just after the capturing edge.
    task automatic press_at_capture(input logic [1:0] r, input logic [3:0] m);
        bit ok;
        prow = r; pmask = m;
        wait_row(r - 2'd1, ok);
        wait_row(r, ok);
        pressed = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] row;
        logic [3:0] mask;
        bit         rd;
        logic [7:0] bus;
        bit         vld;
        bit         ovr;
        logic [7:0] ech;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        vt[0] = '{2'd1, 4'b0100, 0, 8'h00, 0, 0, EchoOn ? 8'h60 : 8'h00};
        vt[1] = '{2'd3, 4'b0001, 1, 8'h6C, 1, 0, EchoOn ? 8'h6C : 8'h00};
        vt[2] = '{2'd0, 4'b0010, 0, 8'h6C, 0, 0, EchoOn ? 8'h10 : 8'h00};
        vt[3] = '{2'd0, 4'b0100, 0, 8'h12, 1, 0, EchoOn ? 8'h12 : 8'h00};
        vt[4] = '{2'd0, 4'b1000, 0, 8'h12, 1, 0, EchoOn ? 8'h30 : 8'h00};
        vt[5] = '{2'd1, 4'b0001, 1, 8'h34, 1, 1, EchoOn ? 8'h34 : 8'h00};
        vt[6] = '{2'd2, 4'b1010, 0, 8'h34, 0, 0, EchoOn ? 8'h90 : 8'h00};
        vt[7] = '{2'd3, 4'b1111, 0, 8'h9C, 1, 0, EchoOn ? 8'h9C : 8'h00};

        cls = 1'b0; ipr_out = 1'b0; pressed = 1'b0; prow = 2'd0; pmask = 4'd0;
        model_reset();
        #1;
        check("reset.row_n", {4'd0, row_n}, 8'h0E);
        check_model("reset");
        repeat (3) @(negedge clk);
        cls = 1'b1;
        @(negedge clk);
        check("post_reset.row_n", {4'd0, row_n}, 8'h0E);

        for (int i = 0; i < 8; i++) begin
            enter_key(vt[i].row, vt[i].mask);
            check($sformatf("vec%0d.bus_out", i), bus_out, vt[i].bus);
            check($sformatf("vec%0d.valid", i), {7'd0, valid}, {7'd0, vt[i].vld});
            check($sformatf("vec%0d.overrun", i), {7'd0, overrun}, {7'd0, vt[i].ovr});
            check($sformatf("vec%0d.echo", i), echo, vt[i].ech);
            if (vt[i].rd) do_read();
        end

        // Byte completes on an edge where ipr_out is high: valid must survive that edge.
        enter_key(2'd0, 4'b0001);
        @(negedge clk);
        ipr_out = 1'b1; prow = 2'd3; pmask = 4'b0010; pressed = 1'b1;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus_out == 8'h0D) found = 1;
        end
        check("race.completion_seen", {7'd0, found}, 8'd1);
        check("race.valid", {7'd0, valid}, 8'd1);
        check("race.overrun", {7'd0, overrun}, 8'd0);
        ipr_out = 1'b0;
        m_valid = 0; m_ovr = 0;
        model_key(key_of(2'd3, 4'b0010));
        repeat (20) @(negedge clk);
        pressed = 1'b0;
        repeat (40) @(negedge clk);
        check_model("race_after");

        // Bounce: column low for exactly one tick after capture.
        press_at_capture(2'd2, 4'b0010);
        pressed = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce.row_held", {4'd0, row_n}, 8'h0B);
        repeat (4) @(negedge clk);
        check("bounce.scan_resumes", {4'd0, row_n}, 8'h07);
        check_model("bounce");
        enter_key(2'd0, 4'b1000);
        enter_key(2'd1, 4'b1000);
        check_model("after_bounce");
        check("after_bounce.byte", bus_out, 8'h37);

        // Reset during debounce of the second nibble.
        enter_key(2'd2, 4'b0100);
        check_model("first_nibble_a");
        press_at_capture(2'd1, 4'b0010);
        ipr_out = 1'b1;
        cls = 1'b0;
        #1;
        model_reset();
        check("midreset.row_n", {4'd0, row_n}, 8'h0E);
        check("midreset.bus_oe", {7'd0, bus_oe}, 8'd1);
        check_model("midreset");
        pressed = 1'b0; ipr_out = 1'b0;
        #1;
        check("midreset.bus_oe_low", {7'd0, bus_oe}, 8'd0);
        repeat (2) @(negedge clk);
        cls = 1'b1;
        enter_key(2'd2, 4'b0100);
        enter_key(2'd1, 4'b0010);
        check("after_reset.byte", bus_out, 8'hA5);
        check_model("after_reset");

        for (int n = 0; n < 16; n++) begin
            logic [1:0] r;
            logic [3:0] m;
            r = 2'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
            enter_key(r, m);
            check_model($sformatf("rand%0d", n));
            if ($urandom_range(0, 2) == 0) do_read();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
